// File: rtl/chess_clock_timer.sv
// Per-player chess clock countdown: prescaled 1 s decrement of a BCD mm:ss value,
// a sticky zero flag, and an optional Fischer increment applied on each turn end.
module chess_clock_timer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int START_MIN = 5,
  parameter int INC_SEC   = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_restart,
  input  logic       i_stop,
  output logic       o_zero,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_tick
);

  localparam int            PW        = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [3:0]    START_MT  = 4'(START_MIN / 10);
  localparam logic [3:0]    START_MO  = 4'(START_MIN % 10);
  localparam logic [3:0]    INC_T     = 4'(INC_SEC / 10);
  localparam logic [3:0]    INC_O     = 4'(INC_SEC % 10);
  localparam logic          INC_EN    = (INC_SEC > 0);

  logic [PW-1:0] presc_q, presc_d;
  logic          hist_q, hist_d;
  logic          tick_q, tick_d;
  logic [3:0]    mt_q, mo_q, st_q, so_q;
  logic [3:0]    mt_d, mo_d, st_d, so_d;
  logic [3:0]    mt_m, mo_m, st_m, so_m;
  logic [3:0]    mt_p, mo_p, st_p, so_p;
  logic [4:0]    so_sum, st_sum, mo_sum, mt_sum;
  logic          c0, c1, c2;
  logic          turn_end;

  assign o_zero     = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
  assign o_min_tens = mt_q;
  assign o_min_ones = mo_q;
  assign o_sec_tens = st_q;
  assign o_sec_ones = so_q;
  assign o_tick     = tick_q;
  assign turn_end   = i_stop && !hist_q;

  // One-second decrement with BCD borrow; only applied while not at 00:00.
  always_comb begin
    mt_m = mt_q;
    mo_m = mo_q;
    st_m = st_q;
    so_m = so_q;
    if (so_q != 4'd0) begin
      so_m = so_q - 4'd1;
    end else begin
      so_m = 4'd9;
      if (st_q != 4'd0) begin
        st_m = st_q - 4'd1;
      end else begin
        st_m = 4'd5;
        if (mo_q != 4'd0) begin
          mo_m = mo_q - 4'd1;
        end else begin
          mo_m = 4'd9;
          mt_m = mt_q - 4'd1;
        end
      end
    end
  end

  // Fischer increment: BCD add with carry out of seconds, saturating at 99:59.
  always_comb begin
    so_sum = {1'b0, so_q} + {1'b0, INC_O};
    c0     = (so_sum >= 5'd10);
    so_p   = c0 ? 4'(so_sum - 5'd10) : so_sum[3:0];
    st_sum = {1'b0, st_q} + {1'b0, INC_T} + {4'd0, c0};
    c1     = (st_sum >= 5'd6);
    st_p   = c1 ? 4'(st_sum - 5'd6) : st_sum[3:0];
    mo_sum = {1'b0, mo_q} + {4'd0, c1};
    c2     = (mo_sum >= 5'd10);
    mo_p   = c2 ? 4'(mo_sum - 5'd10) : mo_sum[3:0];
    mt_sum = {1'b0, mt_q} + {4'd0, c2};
    mt_p   = mt_sum[3:0];
    if (mt_sum >= 5'd10) begin
      mt_p = 4'd9;
      mo_p = 4'd9;
      st_p = 4'd5;
      so_p = 4'd9;
    end
  end

  always_comb begin
    presc_d = presc_q;
    hist_d  = i_stop;
    tick_d  = 1'b0;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    if (i_restart) begin
      presc_d = '0;
      hist_d  = 1'b1;
      mt_d    = START_MT;
      mo_d    = START_MO;
      st_d    = 4'd0;
      so_d    = 4'd0;
    end else if (!o_zero) begin
      if (turn_end && INC_EN) begin
        mt_d = mt_p;
        mo_d = mo_p;
        st_d = st_p;
        so_d = so_p;
      end else if (!i_stop) begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          tick_d  = 1'b1;
          mt_d    = mt_m;
          mo_d    = mo_m;
          st_d    = st_m;
          so_d    = so_m;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q <= '0;
      hist_q  <= 1'b1;
      tick_q  <= 1'b0;
      mt_q    <= START_MT;
      mo_q    <= START_MO;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
    end else begin
      presc_q <= presc_d;
      hist_q  <= hist_d;
      tick_q  <= tick_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
    end
  end

endmodule

// File: tb/tb_chess_clock_timer.sv
// Three timer instances (1 min +5 s, 99 min +59 s, 1 min no increment) checked every
// cycle against a seconds-count model, plus hand-computed literal checkpoints.
module tb_chess_clock_timer;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      stop_r = 3'b010;
  logic [2:0]      restart_r = 3'b000;
  logic [2:0]      zero_o, tick_o;
  logic [2:0][3:0] mt_o, mo_o, st_o, so_o;

  int n_cmp = 0;
  int n_bad = 0;

  int m_secs[3];
  int m_presc[3];
  int m_hist[3];
  int m_tick[3];

  always #5 clk = ~clk;

  chess_clock_timer #(.CLK_HZ(4), .START_MIN(1), .INC_SEC(5)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart_r[0]), .i_stop(stop_r[0]),
    .o_zero(zero_o[0]), .o_min_tens(mt_o[0]), .o_min_ones(mo_o[0]),
    .o_sec_tens(st_o[0]), .o_sec_ones(so_o[0]), .o_tick(tick_o[0]));

  chess_clock_timer #(.CLK_HZ(4), .START_MIN(99), .INC_SEC(59)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart_r[1]), .i_stop(stop_r[1]),
    .o_zero(zero_o[1]), .o_min_tens(mt_o[1]), .o_min_ones(mo_o[1]),
    .o_sec_tens(st_o[1]), .o_sec_ones(so_o[1]), .o_tick(tick_o[1]));

  chess_clock_timer #(.CLK_HZ(4), .START_MIN(1), .INC_SEC(0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart_r[2]), .i_stop(stop_r[2]),
    .o_zero(zero_o[2]), .o_min_tens(mt_o[2]), .o_min_ones(mo_o[2]),
    .o_sec_tens(st_o[2]), .o_sec_ones(so_o[2]), .o_tick(tick_o[2]));

  function automatic int start_min(int i);
    return (i == 1) ? 99 : 1;
  endfunction

  function automatic int inc_sec(int i);
    return (i == 0) ? 5 : ((i == 1) ? 59 : 0);
  endfunction

  task automatic chk(string nm, int i, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, i, $time, act, exp);
    end
  endtask

  // Digits packed as 16'hMMSS so a literal reads like the display.
  task automatic lit(string nm, int i, logic [15:0] exp_digits, int exp_zero, int exp_tick);
    chk({nm, ".digits"}, i, int'({mt_o[i], mo_o[i], st_o[i], so_o[i]}), int'(exp_digits));
    chk({nm, ".zero"}, i, int'(zero_o[i]), exp_zero);
    chk({nm, ".tick"}, i, int'(tick_o[i]), exp_tick);
  endtask

  // Model: time kept as whole seconds remaining, sub-second progress as a cycle count.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_secs[i]  = start_min(i) * 60;
        m_presc[i] = 0;
        m_hist[i]  = 1;
        m_tick[i]  = 0;
      end else if (restart_r[i]) begin
        m_secs[i]  = start_min(i) * 60;
        m_presc[i] = 0;
        m_hist[i]  = 1;
        m_tick[i]  = 0;
      end else begin
        m_tick[i] = 0;
        if (m_secs[i] == 0) begin
          m_tick[i] = 0;
        end else if (stop_r[i] && m_hist[i] == 0 && inc_sec(i) > 0) begin
          m_secs[i] = (m_secs[i] + inc_sec(i) > 5999) ? 5999 : m_secs[i] + inc_sec(i);
        end else if (!stop_r[i]) begin
          m_presc[i] = m_presc[i] + 1;
          if (m_presc[i] == 4) begin
            m_presc[i] = 0;
            m_tick[i]  = 1;
            m_secs[i]  = m_secs[i] - 1;
          end
        end
        m_hist[i] = int'(stop_r[i]);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("min_tens", i, int'(mt_o[i]), (m_secs[i] / 60) / 10);
      chk("min_ones", i, int'(mo_o[i]), (m_secs[i] / 60) % 10);
      chk("sec_tens", i, int'(st_o[i]), (m_secs[i] % 60) / 10);
      chk("sec_ones", i, int'(so_o[i]), (m_secs[i] % 60) % 10);
      chk("zero", i, int'(zero_o[i]), (m_secs[i] == 0) ? 1 : 0);
      chk("tick", i, int'(tick_o[i]), m_tick[i]);
    end
  end

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    wait_n(2);
    rst_n = 1'b1;
    lit("a_reset", 0, 16'h0100, 0, 0);
    lit("b_reset", 1, 16'h9900, 0, 0);
    fork
      begin
        wait_n(8);
        lit("a_two_ticks", 0, 16'h0058, 0, 1);
        stop_r[0] = 1'b1;
        wait_n(1);
        lit("a_increment", 0, 16'h0103, 0, 0);
        stop_r[0] = 1'b0;
        wait_n(252);
        lit("a_expired", 0, 16'h0000, 1, 1);
        stop_r[0] = 1'b1;
        wait_n(1);
        stop_r[0] = 1'b0;
        wait_n(1);
        stop_r[0] = 1'b1;
        wait_n(1);
        lit("a_no_resurrect", 0, 16'h0000, 1, 0);
        restart_r[0] = 1'b1;
        wait_n(1);
        lit("a_restart", 0, 16'h0100, 0, 0);
        restart_r[0] = 1'b0;
        stop_r[0] = 1'b0;
        wait_n(3);
        restart_r[0] = 1'b1;
        wait_n(1);
        lit("a_restart_on_wrap", 0, 16'h0100, 0, 0);
        restart_r[0] = 1'b0;
        wait_n(1);
        stop_r[0] = 1'b1;
        restart_r[0] = 1'b1;
        wait_n(1);
        lit("a_restart_on_turn_end", 0, 16'h0100, 0, 0);
        restart_r[0] = 1'b0;
        wait_n(2);
        lit("a_after_restart_hold", 0, 16'h0100, 0, 0);
      end
      begin
        wait_n(1);
        stop_r[1] = 1'b0;
        wait_n(1);
        stop_r[1] = 1'b1;
        wait_n(1);
        lit("b_inc_59", 1, 16'h9959, 0, 0);
        stop_r[1] = 1'b0;
        wait_n(1);
        stop_r[1] = 1'b1;
        wait_n(1);
        lit("b_saturate", 1, 16'h9959, 0, 0);
        stop_r[1] = 1'b0;
        wait_n(2);
        lit("b_tick", 1, 16'h9958, 0, 1);
        stop_r[1] = 1'b1;
        wait_n(1);
        lit("b_saturate_carry", 1, 16'h9959, 0, 0);
      end
      begin
        wait_n(2);
        stop_r[2] = 1'b1;
        wait_n(10);
        lit("c_frozen_no_inc", 2, 16'h0100, 0, 0);
        stop_r[2] = 1'b0;
        wait_n(2);
        lit("c_resume_tick", 2, 16'h0059, 0, 1);
        wait_n(1);
        lit("c_tick_one_cycle", 2, 16'h0059, 0, 0);
        wait_n(235);
        lit("c_expired", 2, 16'h0000, 1, 1);
        wait_n(8);
        lit("c_stays_expired", 2, 16'h0000, 1, 0);
      end
    join
    stop_r = 3'b000;
    wait_n(5);
    lit("a_before_async_rst", 0, 16'h0059, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    lit("a_async_rst", 0, 16'h0100, 0, 0);
    lit("c_async_rst", 2, 16'h0100, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(3);
    lit("a_presc_from_zero", 0, 16'h0100, 0, 0);
    wait_n(1);
    lit("a_first_tick_after_rst", 0, 16'h0059, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chess_clock_timer.md
Name: chess_clock_timer

Overview:
- Per-player countdown timer; two instances (player A, player B) sit beside the chess clock control FSM.
- Consumes the FSM's per-player stop line and restart strobe.
- Produces the zero flag that the FSM uses to declare the opponent's win, plus BCD mm:ss digits for the display driver.
- Supports an optional per-move Fischer increment, added when the player's turn ends.

Parameters:
- CLK_HZ, 100_000_000, i_clk frequency; the prescaler divides it to a 1 s tick (minimum 2).
- START_MIN, 5, initial time in minutes loaded at reset/restart (1..99); seconds load as 00.
- INC_SEC, 0, seconds added on each turn end (0..59); 0 disables the increment.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_restart  in  1  synchronous reload strobe from the FSM (level; held several cycles is legal).
- i_stop  in  1  1 = timer frozen, 0 = timer counting (the FSM's player stop output).
- o_zero  out  1  time is 00:00; the FSM's player zero input.
- o_min_tens  out  4  BCD minutes tens.
- o_min_ones  out  4  BCD minutes ones.
- o_sec_tens  out  4  BCD seconds tens (0..5).
- o_sec_ones  out  4  BCD seconds ones.
- o_tick  out  1  one-cycle pulse on each second decrement (for display blink / debug).

Behaviour:
- Reset (i_rst_n=0, asynchronous): digits = START_MIN:00, prescaler = 0, stop history register = 1, o_tick = 0, o_zero = 0.
- All outputs are registered or decoded directly from registers; o_zero = (all four digits == 0).
- Priority per cycle: restart > expired hold > increment > count.
- Restart: i_restart=1 loads START_MIN:00, clears the prescaler and sets stop history = 1. It overrides counting, increment and expiry in the same cycle. New values are visible the next cycle.
- Counting: when i_stop=0 and o_zero=0, the prescaler increments each cycle.
  - At CLK_HZ-1 the prescaler wraps to 0, o_tick pulses for one cycle and the time decrements by 1 s.
  - BCD borrow chain on decrement: sec_ones 0 -> 9 with borrow; sec_tens 0 -> 5 with borrow; min_ones 0 -> 9 with borrow; min_tens decrements.
  - Example sequence: 10:00 -> 09:59, 01:00 -> 00:59.
- Frozen: when i_stop=1, the prescaler holds its value, so the partial second is preserved across turns. No tick occurs and the time holds.
- Expiry: the decrement that reaches 00:00 raises o_zero on the next cycle.
  - After expiry the prescaler stops, no further ticks occur and the time never wraps below 00:00.
  - o_zero stays high until restart or reset, regardless of i_stop.
- Increment: stop history register = i_stop delayed one cycle. A turn end is i_stop=1 with history=0.
  - On a turn end with INC_SEC>0 and o_zero=0, add INC_SEC with BCD carry (seconds mod 60, carry into minutes).
  - The result saturates at 99:59. The prescaler is untouched.
  - A turn end on the same cycle as restart is ignored.
  - A turn end while o_zero=1 is ignored (no resurrection after flag fall).
- Tick vs stop: there is no tick in any cycle with i_stop=1, so a turn end and a decrement never coincide.
- Glitch-free: the digit registers update only on tick, increment, restart or reset.

Test Plan:
- CLK_HZ=4, START_MIN=1, INC_SEC=0, reset then i_stop=0 -> o_tick every 4 cycles; digits 01:00 -> 00:59 after 4 cycles; 00:00 after 240 cycles; o_zero=1 on the next cycle and stays high with no further ticks.
- CLK_HZ=4; run 2 cycles, i_stop=1 for 10 cycles, i_stop=0 -> first tick arrives 2 cycles after resume (prescaler retained); time holds during the stop.
- CLK_HZ=4, START_MIN=1, INC_SEC=5; run until 00:58, raise i_stop -> 01:03 the next cycle. Separately, preload near the cap (START_MIN=99, INC_SEC=59, toggle stop) -> stays 99:59.
- Expired at 00:00, toggle i_stop 1->0->1 -> no increment, o_zero stays 1. Then i_restart=1 -> 01:00 and o_zero=0 the next cycle.
- Assert i_restart on the same cycle as a prescaler wrap and on the same cycle as a turn-end edge -> digits = START_MIN:00, no o_tick, no increment.
- Drop i_rst_n mid-count, asynchronously between clock edges -> outputs show START_MIN:00 and o_zero=0 immediately, without waiting for a clock edge. Counting resumes only after release, with the prescaler restarting from 0.
